// File: rtl/num_to_ascii_pkg.sv
// Shared definitions for the RPN calculator character path.
// Contents:
//   ascii_t      - ASCII codes shared with the alu (digits base, operators, brackets)
//   state_t      - formatter FSM states
//   digit_char() - maps a 0..9 digit to its ASCII character
package num_to_ascii_pkg;

    typedef enum logic [7:0] {
        BRACKET_OPEN  = 8'h28,
        BRACKET_CLOSE = 8'h29,
        MUL_SGN       = 8'h2a,
        PLUS_SGN      = 8'h2b,
        MINUS_SGN     = 8'h2d,
        DIV_SGN       = 8'h2f,
        NUM_0         = 8'h30,
        EQU_SGN       = 8'h3d
    } ascii_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIV    = 3'd1,
        SIGN   = 3'd2,
        DIGITS = 3'd3,
        TERM   = 3'd4
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return NUM_0 + {4'b0000, d};
    endfunction

endpackage

// File: rtl/num_to_ascii_div10_seq.sv
// Sequential restoring divide by 10.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   start         - begin a divide of 'dividend' (only honoured when not busy)
//   dividend      - WIDTH-bit unsigned value
//   busy          - iterations still in progress
//   done          - one-cycle pulse; quotient/remainder valid while high
//   quotient      - dividend / 10
//   remainder     - dividend % 10
// The start edge already performs the first iteration, so a divide takes
// exactly WIDTH edges from start to the edge that raises done.
module num_to_ascii_div10_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [3:0]       remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_reg, q_next;
    logic [3:0]       r_reg, r_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic             load;
    logic [WIDTH-1:0] src;
    logic [4:0]       trial;
    logic             qbit;

    assign busy      = (cnt_reg != '0);
    assign done      = done_reg;
    assign quotient  = q_reg;
    assign remainder = r_reg;

    always_comb begin
        load      = start && !busy;
        // q_reg shifts dividend bits out at the top and quotient bits in at the bottom.
        src       = load ? dividend : q_reg;
        trial     = {(load ? 4'd0 : r_reg), src[WIDTH-1]};
        qbit      = (trial >= 5'd10);
        q_next    = q_reg;
        r_next    = r_reg;
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        if (load || busy) begin
            r_next    = qbit ? 4'(trial - 5'd10) : trial[3:0];
            q_next    = {src[WIDTH-2:0], qbit};
            cnt_next  = load ? CW'(WIDTH - 1) : cnt_reg - 1'b1;
            done_next = (cnt_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg    <= '0;
            r_reg    <= '0;
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            r_reg    <= r_next;
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

endmodule

// File: rtl/num_to_ascii.sv
// Formats one signed value per val_stb/val_ack handshake as ASCII decimal,
// most significant digit first, optional '-' prefix and optional terminator,
// on an out_stb/out_ack character stream.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   val_stb/val - value offer; taken only in IDLE
//   val_ack     - one-cycle pulse after the capture edge
//   out_stb     - out_char valid, held until an out_ack edge
//   out_char    - ASCII character, bit 0 is the MSB
//   out_ack     - sink consumed out_char on this edge
module num_to_ascii
    import num_to_ascii_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter logic [7:0] TERM_CHAR = 8'h0a,
    parameter bit         EMIT_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             val_stb,
    input  logic [WIDTH-1:0] val,
    output logic             val_ack,
    output logic             out_stb,
    output logic [0:7]       out_char,
    input  logic             out_ack
);

    localparam int NDIG = (WIDTH * 3 + 9) / 10;
    localparam int SPW  = $clog2(NDIG + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] mag_reg;
    logic             neg_reg;
    logic [SPW-1:0]   sp_reg;
    logic [SPW-1:0]   pop_idx;
    logic             val_ack_reg;
    logic             out_stb_reg, out_stb_next;
    logic [7:0]       out_char_reg, out_char_next;

    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quot;
    logic [3:0]       div_rem;

    logic             capture, push, load, consume, tx_state;
    logic [WIDTH-1:0] abs_val;
    logic [2**SPW-1:0][3:0] lifo_flat;

    assign val_ack  = val_ack_reg;
    assign out_stb  = out_stb_reg;
    assign out_char = out_char_reg;

    // Two's-complement negate in WIDTH bits: the most negative value maps to
    // its own bit pattern, which read unsigned is the correct magnitude.
    assign abs_val = val[WIDTH-1] ? (~val + 1'b1) : val;
    assign pop_idx = sp_reg - 1'b1;

    always_comb begin
        capture   = (state_reg == IDLE) && val_stb;
        div_start = (state_reg == DIV) && !div_busy && !div_done;
        push      = (state_reg == DIV) && div_done;
        tx_state  = (state_reg == SIGN) || (state_reg == DIGITS) || (state_reg == TERM);
        // An empty LIFO in DIGITS must not present a character.
        load      = tx_state && !out_stb_reg && !((state_reg == DIGITS) && (sp_reg == '0));
        consume   = out_stb_reg && out_ack;
    end

    num_to_ascii_div10_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag_reg),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Digit LIFO; entries beyond NDIG are never addressed and stay zero.
    for (genvar gi = 0; gi < 2**SPW; gi++) begin : g_lifo
        if (gi < NDIG) begin : g_entry
            logic [3:0] entry_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    entry_reg <= '0;
                else if (push && (sp_reg == SPW'(gi)))
                    entry_reg <= div_rem;
            end
            assign lifo_flat[gi] = entry_reg;
        end else begin : g_pad
            assign lifo_flat[gi] = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic. In DIGITS sp_reg was already decremented when the
    // character was loaded, so sp_reg==0 at consume means it was the last digit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (capture) state_next = DIV;
            DIV:     if (push && (div_quot == '0)) state_next = neg_reg ? SIGN : DIGITS;
            SIGN:    if (consume) state_next = DIGITS;
            DIGITS:  if ((consume || !out_stb_reg) && (sp_reg == '0))
                         state_next = EMIT_TERM ? TERM : IDLE;
            TERM:    if (consume) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered character stream.
    always_comb begin
        out_stb_next  = out_stb_reg;
        out_char_next = out_char_reg;
        if (load) begin
            out_stb_next = 1'b1;
            case (state_reg)
                SIGN:    out_char_next = MINUS_SGN;
                DIGITS:  out_char_next = digit_char(lifo_flat[pop_idx]);
                default: out_char_next = TERM_CHAR;
            endcase
        end else if (consume) begin
            out_stb_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag_reg      <= '0;
            neg_reg      <= 1'b0;
            sp_reg       <= '0;
            val_ack_reg  <= 1'b0;
            out_stb_reg  <= 1'b0;
            out_char_reg <= '0;
        end else begin
            val_ack_reg  <= capture;
            out_stb_reg  <= out_stb_next;
            out_char_reg <= out_char_next;
            if (capture) begin
                mag_reg <= abs_val;
                neg_reg <= val[WIDTH-1];
            end else if (push) begin
                mag_reg <= div_quot;
            end
            if (push)
                sp_reg <= sp_reg + 1'b1;
            else if (load && (state_reg == DIGITS))
                sp_reg <= pop_idx;
        end
    end

endmodule

// File: tb/tb_num_to_ascii.sv
// Bench for num_to_ascii (WIDTH=16, TERM_CHAR=8'h0a, EMIT_TERM=1).
module tb_num_to_ascii;

    logic        clk;
    logic        reset;
    logic        val_stb;
    logic [15:0] val;
    logic        val_ack;
    logic        out_stb;
    logic [0:7]  out_char;
    logic        out_ack;

    int total = 0;
    int bad   = 0;
    int ack_cnt = 0;

    byte exp_q[$];
    int  exp_k;

    typedef struct {
        logic [15:0] v;
        int          hold0;
        string       s;
    } vec_t;

    vec_t tbl[9];

    num_to_ascii dut (
        .clk      (clk),
        .reset    (reset),
        .val_stb  (val_stb),
        .val      (val),
        .val_ack  (val_ack),
        .out_stb  (out_stb),
        .out_char (out_char),
        .out_ack  (out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (val_ack === 1'b1) ack_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the signed value.
    task automatic model_expect(input logic [15:0] v);
        int  s;
        int  m;
        byte d[$];
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        exp_q.delete();
        do begin
            d.push_front(byte'(8'h30 + m % 10));
            m = m / 10;
        end while (m != 0);
        exp_k = d.size();
        if (s < 0) exp_q.push_back(8'h2d);
        foreach (d[i]) exp_q.push_back(d[i]);
        exp_q.push_back(8'h0a);
    endtask

    task automatic str_expect(input string s);
        exp_q.delete();
        exp_k = 0;
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
            if (s[i] != "-") exp_k++;
        end
        exp_q.push_back(8'h0a);
    endtask

    // Offers v, then receives and checks every character in exp_q.
    // spam keeps val_stb high (with 99) until the last character is consumed.
    task automatic run_expect(input string name, input logic [15:0] v, input int hold0,
                              input bit rand_hold, input bit spam);
        int lat;
        int n;
        int hold;
        int extra;
        int start_acks;
        start_acks = ack_cnt;
        @(negedge clk);
        val = v;
        val_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (spam) val = 16'd99;
        else val_stb = 1'b0;
        check(val_ack === 1'b1, {name, " val_ack"}, longint'(val_ack), 1);
        lat = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            while (out_stb !== 1'b1 && n < 200) begin
                @(negedge clk);
                lat++;
                n++;
            end
            check(out_stb === 1'b1, $sformatf("%s timeout char%0d", name, i), longint'(out_stb), 1);
            if (out_stb !== 1'b1) begin
                val_stb = 1'b0;
                return;
            end
            printf_char(name, i);
            if (i == 0)
                check(lat == 1 + exp_k * 17, {name, " latency"}, lat, 1 + exp_k * 17);
            check(out_char == exp_q[i], $sformatf("%s char%0d", name, i),
                  longint'(out_char), longint'(exp_q[i]));
            hold = (i == 0) ? hold0 : (rand_hold ? int'($urandom_range(0, 2)) : 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check(out_stb === 1'b1 && out_char == exp_q[i], $sformatf("%s hold%0d", name, h),
                      longint'({out_stb, out_char}), longint'({1'b1, exp_q[i]}));
            end
            out_ack = 1'b1;
            @(negedge clk);
            out_ack = 1'b0;
            if (spam && i == exp_q.size() - 1) val_stb = 1'b0;
            check(out_stb === 1'b0, $sformatf("%s drop%0d", name, i), longint'(out_stb), 0);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_stb === 1'b1) extra++;
        end
        check(extra == 0, {name, " extra chars"}, extra, 0);
        check(ack_cnt - start_acks == 1, {name, " val_ack count"}, ack_cnt - start_acks, 1);
        $display("txn %s val=%0d chars=%0d", name, $signed(v), exp_q.size());
    endtask

    task automatic printf_char(input string name, input int i);
        if (i < 0) $display("%s", name);
    endtask

    task automatic wait_char(input string name, input byte c);
        int n;
        n = 0;
        while (out_stb !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(out_stb === 1'b1 && out_char == c, {name, " char"},
              longint'({out_stb, out_char}), longint'({1'b1, c}));
    endtask

    initial begin
        reset   = 1'b0;
        val_stb = 1'b0;
        val     = '0;
        out_ack = 1'b0;

        tbl[0] = '{16'd21,    0, "21"};
        tbl[1] = '{16'd0,     0, "0"};
        tbl[2] = '{16'hffff,  0, "-1"};
        tbl[3] = '{16'h8000,  0, "-32768"};
        tbl[4] = '{16'd405,   5, "405"};
        tbl[5] = '{16'h7fff,  1, "32767"};
        tbl[6] = '{16'd10,    0, "10"};
        tbl[7] = '{16'd9,     2, "9"};
        tbl[8] = '{16'hfff6,  0, "-10"};

        @(negedge clk);
        check(out_stb === 1'b0 && val_ack === 1'b0 && out_char === 8'h00, "reset state",
              longint'({out_stb, val_ack, out_char}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            str_expect(tbl[i].s);
            run_expect($sformatf("tbl%0d", i), tbl[i].v, tbl[i].hold0, 1'b0, 1'b0);
        end

        // Reset abandons a value mid-output, with no clock edge needed.
        @(negedge clk);
        val = 16'd12345;
        val_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        val_stb = 1'b0;
        wait_char("rst c0", 8'h31);
        out_ack = 1'b1; @(negedge clk); out_ack = 1'b0;
        wait_char("rst c1", 8'h32);
        out_ack = 1'b1; @(negedge clk); out_ack = 1'b0;
        wait_char("rst c2", 8'h33);
        #2 reset = 1'b0;
        #1 check(out_stb === 1'b0 && out_char === 8'h00, "async reset",
                 longint'({out_stb, out_char}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        $display("txn reset-abandon val=12345");
        str_expect("7");
        run_expect("after_rst", 16'd7, 0, 1'b0, 1'b0);

        // val_stb while busy is ignored, then accepted once idle.
        str_expect("3");
        run_expect("busy3", 16'd3, 0, 1'b0, 1'b1);
        str_expect("99");
        run_expect("then99", 16'd99, 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (r == 0) v = 16'h8001;
            model_expect(v);
            run_expect($sformatf("rnd%0d", r), v, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
